mdu_sched: RTL and testbench
============================

Name: mdu_sched

Overview:
- Multi-cycle multiply/divide scheduler and HI/LO owner for the 5-stage pipeline.
- Accepts the E-stage MDU command (mode plus start pulse) and captures the operands.
- Holds the unit busy for a fixed latency, then commits the result to HI/LO.
- Raises the D-stage stall whenever an MD/HILO-class instruction would collide with an operation still in flight.

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu (≥1)
- DIV_LAT, 10, busy cycles for div/divu (≥1)
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- e_mdu_mod  in  3  E-stage MDU mode (package encoding)
- e_mdu_start  in  1  E-stage start pulse; valid only with modes 0..3
- e_a  in  32  rs value (forwarded)
- e_b  in  32  rt value (forwarded)
- d_is_md_instr  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall  out  1  freeze PC/D, bubble into E
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (sync, highest priority):
  - busy=0, cnt=0, hi=0, lo=0, pending results=0.
  - Reset mid-operation aborts the operation; no commit occurs.
- State: IDLE (cnt==0) / BUSY (cnt!=0); busy = (cnt!=0), combinational from the register.
- Start, at edge t with e_mdu_start=1, mode 0..3 and IDLE:
  - Compute and latch pend_hi/pend_lo.
  - Load cnt = MUL_LAT (modes 0,1) or DIV_LAT (modes 2,3).
- While BUSY: cnt decrements each edge. At the edge where cnt==1, hi/lo <= pend_hi/pend_lo and cnt <= 0.
- Latency: busy=1 for exactly LAT cycles after edge t. New hi/lo are visible in the first cycle busy=0.
- mult (0): {hi,lo} = signed 64-bit product. multu (1): unsigned product.
- div (2), signed:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu (3): unsigned quotient and remainder.
- Divide by zero: operation still takes DIV_LAT busy cycles; hi/lo keep their prior values (no commit).
- mthi (4): hi <= e_a at the edge, only if IDLE. mtlo (5): lo <= e_a, only if IDLE. Both are single-cycle and never set busy.
- Mode 7 (none) and mode 6 (reserved): no effect.
- e_mdu_start=1 while BUSY is illegal and is ignored; the bench asserts it never happens.
- Mode 4/5 while BUSY is ignored, and the stall rule prevents it.
- stall = d_is_md_instr & (busy | e_mdu_start), combinational. The start term covers the cycle before busy rises.
- mfhi/mflo read hi/lo directly. After the commit edge the stall is already released, so no extra bypass is needed.
- Simultaneous commit and start: cannot occur, since start requires IDLE.

Decomposition:
- Shared package holds:
  - MDU mode constants: MUL_S=0, MUL_U=1, DIV_S=2, DIV_U=3, TO_HI=4, TO_LO=5, NONE=7.
  - Default latency constants.
- One sub-module, mdu_arith: a combinational 32x32 signed/unsigned multiply and divide that returns {hi,lo} and a div0 flag. The scheduler holds the counter, the pending registers and HI/LO.

Test Plan:
- Reset, then mult with e_a=0xFFFFFFFE (-2), e_b=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with e_a=0xFFFFFFFF, e_b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div with e_a=0xFFFFFFF9 (-7), e_b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu by zero after mthi 0x12345678 → busy 10 cycles; hi stays 0x12345678, lo unchanged.
- Start div with d_is_md_instr=1 held → stall=1 from the start cycle through all 10 busy cycles, and 0 in the commit-visible cycle. With d_is_md_instr=0 → stall=0 throughout.
- Reset asserted at busy cycle 3 of a mult → busy=0 and hi=lo=0 next cycle; no later commit.

Source files
------------

// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: MDU mode encoding
// and default operation latencies.
package mdu_sched_pkg;

    typedef enum logic [2:0] {
        MUL_S = 3'd0,
        MUL_U = 3'd1,
        DIV_S = 3'd2,
        DIV_U = 3'd3,
        TO_HI = 3'd4,
        TO_LO = 3'd5,
        RSVD  = 3'd6,
        NONE  = 3'd7
    } mdu_mode_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W_DEF   = 4;

    // Modes 0..3 are the multi-cycle arithmetic operations.
    function automatic logic is_md_op(input logic [2:0] mode);
        return (mode[2] == 1'b0);
    endfunction

    function automatic logic is_div_op(input logic [2:0] mode);
        return (mode[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply/divide returning {hi,lo} and a divide-by-zero
// flag; the scheduler decides when (and whether) the result is committed.
module mdu_arith
    import mdu_sched_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div0_o
);

    logic        [63:0] uprod_s;
    logic signed [63:0] sprod_s;
    logic        [31:0] b_safe_s;
    logic               ovf_s;
    logic signed [31:0] squot_s;
    logic signed [31:0] srem_s;
    logic        [31:0] uquot_s;
    logic        [31:0] urem_s;

    assign div0_o   = (b_i == 32'd0);
    // Divisor forced to 1 on zero so the dividers never see a zero operand.
    assign b_safe_s = div0_o ? 32'd1 : b_i;
    assign ovf_s    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    assign uprod_s = {32'd0, a_i} * {32'd0, b_i};
    assign sprod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign uquot_s = a_i / b_safe_s;
    assign urem_s  = a_i % b_safe_s;
    assign squot_s = ovf_s ? 32'sh8000_0000 : ($signed(a_i) / $signed(b_safe_s));
    assign srem_s  = ovf_s ? 32'sd0         : ($signed(a_i) % $signed(b_safe_s));

    // Select the result pair for the requested operation.
    always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        case (mode_i)
            MUL_S: begin
                hi_o = sprod_s[63:32];
                lo_o = sprod_s[31:0];
            end
            MUL_U: begin
                hi_o = uprod_s[63:32];
                lo_o = uprod_s[31:0];
            end
            DIV_S: begin
                hi_o = srem_s;
                lo_o = squot_s;
            end
            DIV_U: begin
                hi_o = urem_s;
                lo_o = uquot_s;
            end
            default: begin
                hi_o = 32'd0;
                lo_o = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide scheduler and HI/LO owner: holds the unit busy
// for a fixed latency, commits to HI/LO, and stalls D-stage MD instructions.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_mdu_mod,
    input  logic        e_mdu_start,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_is_md_instr,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [31:0]      hi_q,       hi_d;
    logic [31:0]      lo_q,       lo_d;
    logic [31:0]      pend_hi_q,  pend_hi_d;
    logic [31:0]      pend_lo_q,  pend_lo_d;
    logic             pend_ok_q,  pend_ok_d;

    logic [31:0]      ar_hi_s;
    logic [31:0]      ar_lo_s;
    logic             ar_div0_s;
    logic             idle_s;

    mdu_arith u_arith (
        .mode_i (e_mdu_mod),
        .a_i    (e_a),
        .b_i    (e_b),
        .hi_o   (ar_hi_s),
        .lo_o   (ar_lo_s),
        .div0_o (ar_div0_s)
    );

    assign idle_s = (cnt_q == {CNT_W{1'b0}});
    assign busy   = !idle_s;
    // The start term covers the cycle before busy rises.
    assign stall  = d_is_md_instr & (busy | e_mdu_start);
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Next-state: start/launch, countdown and commit, and mthi/mtlo writes.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        if (idle_s) begin
            if (e_mdu_start && is_md_op(e_mdu_mod)) begin
                pend_hi_d = ar_hi_s;
                pend_lo_d = ar_lo_s;
                // A zero divisor still occupies the unit but must not commit.
                pend_ok_d = !(is_div_op(e_mdu_mod) && ar_div0_s);
                cnt_d     = is_div_op(e_mdu_mod) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            end else if (e_mdu_mod == TO_HI) begin
                hi_d = e_a;
            end else if (e_mdu_mod == TO_LO) begin
                lo_d = e_a;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            if ((cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) && pend_ok_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end else begin
                hi_d = hi_q;
            end
        end
    end

    // State registers with synchronous reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= {CNT_W{1'b0}};
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_ok_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed test-plan steps followed by a
// randomized run, all compared against a cycle-count based reference model.
module tb_mdu_sched;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  e_mdu_mod;
    logic        e_mdu_start;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_is_md_instr;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    // Reference model: an operation started on edge number t commits on edge t+LAT.
    longint      edge_no  = 0;
    longint      done_at  = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;
    logic [31:0] m_phi    = 32'd0;
    logic [31:0] m_plo    = 32'd0;
    logic        m_pok    = 1'b0;

    mdu_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .e_mdu_mod     (e_mdu_mod),
        .e_mdu_start   (e_mdu_start),
        .e_a           (e_a),
        .e_b           (e_b),
        .d_is_md_instr (d_is_md_instr),
        .busy          (busy),
        .stall         (stall),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of an MDU operation, from plain 64-bit arithmetic.
    task automatic ref_op(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output logic ok);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ok = 1'b1;
        p  = 64'd0;
        q  = 64'd0;
        r  = 64'd0;
        case (mode)
            3'd0: p = sa * sb;
            3'd1: p = ua * ub;
            3'd2: if (b != 32'd0) begin q = sa / sb; r = sa % sb; end else ok = 1'b0;
            3'd3: if (b != 32'd0) begin q = ua / ub; r = ua % ub; end else ok = 1'b0;
            default: ok = 1'b0;
        endcase
        if (mode[1]) begin
            rh = r[31:0];
            rl = q[31:0];
        end else begin
            rh = p[63:32];
            rl = p[31:0];
        end
    endtask

    function automatic logic m_busy();
        return (edge_no < done_at);
    endfunction

    // One clock cycle: drive, check stall before the edge, update model, check after.
    task automatic step(input logic rst, input logic [2:0] mode, input logic st,
                        input logic [31:0] a, input logic [31:0] b, input logic dmd);
        logic        was_busy;
        logic [31:0] rh, rl;
        logic        ok;
        reset = rst; e_mdu_mod = mode; e_mdu_start = st;
        e_a = a; e_b = b; d_is_md_instr = dmd;
        #1;
        was_busy = m_busy();
        if (st && was_busy && !rst)
            $error("bench drove start while busy");
        chk("stall", {31'd0, stall}, {31'd0, dmd & (was_busy | st)});
        @(posedge clk);
        edge_no++;
        if (rst) begin
            done_at = edge_no;
            m_hi = 32'd0; m_lo = 32'd0; m_pok = 1'b0;
        end else if (!was_busy) begin
            if (st && mode <= 3'd3) begin
                ref_op(mode, a, b, rh, rl, ok);
                m_phi = rh; m_plo = rl; m_pok = ok;
                done_at = edge_no + ((mode <= 3'd1) ? MUL_LAT : DIV_LAT);
            end else if (mode == 3'd4) begin
                m_hi = a;
            end else if (mode == 3'd5) begin
                m_lo = a;
            end
        end else if (edge_no == done_at && m_pok) begin
            m_hi = m_phi; m_lo = m_plo;
        end
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_busy()});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic idle(input int n, input logic dmd);
        for (int i = 0; i < n; i++) step(1'b0, 3'd7, 1'b0, 32'd0, 32'd0, dmd);
    endtask

    initial begin
        logic [2:0]  rm;
        logic [31:0] ra, rb;
        logic        rs, rd, rr;

        step(1'b1, 3'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 3'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);

        // mult -2 * 3
        step(1'b0, 3'd0, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MUL_LAT, 1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // multu 0xFFFFFFFF * 2
        step(1'b0, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MUL_LAT, 1'b0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // div -7 / 2
        step(1'b0, 3'd2, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_LAT, 1'b0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // div overflow case
        step(1'b0, 3'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV_LAT, 1'b0);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);

        // mthi then divu by zero: no commit
        step(1'b0, 3'd4, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
        step(1'b0, 3'd3, 1'b1, 32'd99, 32'd0, 1'b0);
        idle(DIV_LAT, 1'b0);
        chk("div0_hi", hi, 32'h1234_5678);
        chk("div0_lo", lo, 32'h8000_0000);

        // stall held through a div with an MD instruction waiting in D
        step(1'b0, 3'd3, 1'b1, 32'd100, 32'd7, 1'b1);
        idle(DIV_LAT, 1'b1);
        step(1'b0, 3'd7, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("stall_rel", {31'd0, stall}, 32'd0);
        step(1'b0, 3'd2, 1'b1, 32'd100, 32'd7, 1'b0);
        idle(DIV_LAT, 1'b0);

        // reset during busy cycle 3 of a mult
        step(1'b0, 3'd0, 1'b1, 32'd1000, 32'd1000, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 3'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_lo", lo, 32'd0);
        idle(MUL_LAT + 2, 1'b0);
        chk("abort_nocommit", lo, 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rm = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) rb = 32'($signed(8'($urandom())));
            rd = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 63) == 0);
            rs = !m_busy() && (rm <= 3'd3) && ($urandom_range(0, 1) == 1);
            step(rr, rm, rs, ra, rb, rd);
        end
        idle(DIV_LAT + 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
